// File: rtl/shift_rotate_seq.sv
// shift_rotate_seq: multi-cycle shift/rotate engine, one bit position per clock.
module shift_rotate_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [CNT_W-1:0] CNT,
    input  logic             CIN,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Y,
    output logic             C,
    output logic             V,
    output logic             N,
    output logic             Z
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nx;
    logic [2:0] op_q;
    logic [CNT_W-1:0] rem;
    logic accept, left, fill;
    logic [WIDTH-1:0] y_step;
    assign accept = start && state != RUN;
    // even op codes shift left; fill is the bit entering the vacated end
    assign left = ~op_q[0];
    assign fill = op_q[2] ? (op_q[1] ? C : (left ? Y[WIDTH-1] : Y[0]))
                          : (op_q[1] & ~left & Y[WIDTH-1]);
    assign y_step = left ? {Y[WIDTH-2:0], fill} : {fill, Y[WIDTH-1:1]};
    assign N = Y[WIDTH-1];
    assign Z = Y == '0;
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= state_nx;
    end
    always_comb begin
        state_nx = state == RUN ? (rem == CNT_W'(1) ? DONE : RUN)
                 : accept ? (CNT == '0 ? DONE : RUN) : IDLE;
    end
    always_comb begin
        busy = state == RUN;
        done = state == DONE;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            Y    <= '0;
            C    <= 1'b0;
            V    <= 1'b0;
            op_q <= '0;
            rem  <= '0;
        end else if (accept) begin
            Y    <= A;
            C    <= CIN;
            V    <= 1'b0;
            op_q <= op;
            rem  <= CNT;
        end else if (state == RUN) begin
            Y   <= y_step;
            C   <= left ? Y[WIDTH-1] : Y[0];
            V   <= V | (op_q == 3'b010 && (Y[WIDTH-1] ^ Y[WIDTH-2]));
            rem <= rem - CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_shift_rotate_seq.sv
// tb_shift_rotate_seq: directed and random operations against an arithmetic reference model.
module tb_shift_rotate_seq;
    logic clk = 0, reset = 1, start = 0, CIN = 0;
    logic [2:0] op = '0, CNT = '0;
    logic [7:0] A = '0, Y;
    logic busy, done, C, V, N, Z;
    int checks = 0, errors = 0;

    shift_rotate_seq dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .CNT(CNT), .CIN(CIN),
        .busy(busy), .done(done), .Y(Y), .C(C), .V(V), .N(N), .Z(Z)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // whole-operation result from shift/rotate arithmetic on wide integers
    function automatic void model(input logic [2:0] o, input logic [7:0] a, input int n,
                                  input logic ci, output logic [7:0] y, output logic c,
                                  output logic v);
        logic [31:0] w;
        logic [8:0] r9;
        logic signed [7:0] sa, sy;
        r9 = {ci, a};
        sa = a;
        v  = 1'b0;
        case (o)
            3'd0, 3'd2: begin
                w = 32'(a) << n;
                y = w[7:0];
                c = n != 0 ? w[8] : ci;
                sy = y;
                if (o == 3'd2) v = (sy >>> n) != sa;
            end
            3'd1: begin
                y = a >> n;
                c = n != 0 ? a[n-1] : ci;
            end
            3'd3: begin
                sy = sa >>> n;
                y = sy;
                c = n != 0 ? a[n-1] : ci;
            end
            3'd4: begin
                w = (32'(a) << n) | (32'(a) >> (8 - n));
                y = w[7:0];
                c = n != 0 ? y[0] : ci;
            end
            3'd5: begin
                w = (32'(a) >> n) | (32'(a) << (8 - n));
                y = w[7:0];
                c = n != 0 ? y[7] : ci;
            end
            3'd6: begin
                w = (32'(r9) << n) | (32'(r9) >> (9 - n));
                y = w[7:0];
                c = w[8];
            end
            default: begin
                w = (32'(r9) >> n) | (32'(r9) << (9 - n));
                y = w[7:0];
                c = w[8];
            end
        endcase
    endfunction

    // b2b: drive start now (caller is in a DONE or IDLE cycle); hold: check one idle cycle after done
    task automatic run_op(input logic [2:0] o, input logic [7:0] a, input logic [2:0] n,
                          input logic ci, input bit b2b, input bit hold);
        logic [7:0] ey, ey1;
        logic ec, ev, ec1, ev1;
        int lat, bcnt;
        model(o, a, int'(n), ci, ey, ec, ev);
        model(o, a, 1, ci, ey1, ec1, ev1);
        if (!b2b) @(negedge clk);
        start = 1; op = o; A = a; CNT = n; CIN = ci;
        @(posedge clk); #1;
        start = 0; lat = 1; bcnt = 0;
        while (!done && lat <= 20) begin
            if (busy) bcnt++;
            if (lat == 2) begin
                chk("step1_y", 32'(Y), 32'(ey1));
                chk("step1_c", 32'(C), 32'(ec1));
                chk("step1_v", 32'(V), 32'(ev1));
            end
            // inputs and a start pulse while running must not disturb the operation
            start = 1'($urandom); op = 3'($urandom); A = 8'($urandom);
            CNT = 3'($urandom); CIN = 1'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        start = 0;
        chk("latency", 32'(lat), 32'(n) + 1);
        chk("busy_cycles", 32'(bcnt), 32'(n));
        chk("y", 32'(Y), 32'(ey));
        chk("c", 32'(C), 32'(ec));
        chk("v", 32'(V), 32'(ev));
        chk("n", 32'(N), 32'(ey[7]));
        chk("z", 32'(Z), 32'(ey == 8'h00));
        if (hold) begin
            @(posedge clk); #1;
            chk("hold_done", 32'(done), 32'(0));
            chk("hold_y", 32'(Y), 32'(ey));
            chk("hold_c", 32'(C), 32'(ec));
        end
    endtask

    initial begin
        int seen;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_y", 32'(Y), 0);
        chk("rst_cv", 32'({C, V, N}), 0);
        chk("rst_z", 32'(Z), 1);
        reset = 0;

        run_op(3'd1, 8'hB5, 3'd3, 1'b0, 0, 1);
        run_op(3'd3, 8'h81, 3'd2, 1'b0, 0, 1);
        run_op(3'd4, 8'h81, 3'd1, 1'b0, 0, 0);
        run_op(3'd7, 8'h01, 3'd2, 1'b0, 1, 1);
        run_op(3'd2, 8'h40, 3'd2, 1'b0, 0, 1);
        run_op(3'd0, 8'h00, 3'd0, 1'b1, 0, 1);
        run_op(3'd5, 8'hC3, 3'd5, 1'b1, 0, 0);
        run_op(3'd6, 8'h5A, 3'd7, 1'b1, 1, 1);

        // reset during RUN aborts without a done pulse
        @(negedge clk);
        start = 1; op = 3'd0; A = 8'hFF; CNT = 3'd5; CIN = 1;
        @(posedge clk); #1;
        start = 0;
        @(posedge clk); #1;
        reset = 1;
        @(posedge clk); #1;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_y", 32'(Y), 0);
        chk("abort_z", 32'(Z), 1);
        chk("abort_cv", 32'({C, V}), 0);
        reset = 0;
        seen = 0;
        repeat (8) begin
            @(posedge clk); #1;
            seen += int'(done);
        end
        chk("abort_no_done", 32'(seen), 0);

        for (int i = 0; i < 200; i++)
            run_op(3'($urandom), 8'($urandom), 3'($urandom), 1'($urandom),
                   ($urandom % 3) == 0, ($urandom % 4) == 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
